// File: rtl/rv32i_decode_execute.sv
// Decode/execute datapath of the multi-cycle RV32I core: decoder, integer ALU and PC unit.
// Define MISALIGN_CHECK_EN to block misaligned control-flow targets and pulse misaligned.
module rv32i_decode_execute #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        decode_en,
    input  logic        execute_en,
    input  logic [31:0] instr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [31:0] op3,
    output logic [4:0]  rd,
    output logic [31:0] pc,
    output logic [31:0] result,
    output logic        alu_valid,
    output logic        halted,
    output logic        misaligned
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic [31:0] dec_op1, dec_op2, dec_op3;
    logic [4:0]  dec_rd;

    always_comb begin
        dec_op1 = '0;
        dec_op2 = '0;
        dec_op3 = '0;
        dec_rd  = '0;
        case (opcode)
            OPC_OP: begin
                dec_op1 = rs1_data;
                dec_op2 = rs2_data;
                dec_rd  = instr[11:7];
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                dec_op1 = rs1_data;
                dec_op2 = imm_i;
                dec_rd  = instr[11:7];
            end
            OPC_STORE: begin
                dec_op1 = rs1_data;
                dec_op2 = imm_s;
                dec_op3 = rs2_data;
            end
            OPC_BRANCH: begin
                dec_op1 = rs1_data;
                dec_op2 = rs2_data;
                dec_op3 = imm_b;
            end
            OPC_LUI: begin
                dec_op2 = imm_u;
                dec_rd  = instr[11:7];
            end
            OPC_AUIPC: begin
                dec_op1 = pc;
                dec_op2 = imm_u;
                dec_rd  = instr[11:7];
            end
            OPC_JAL: begin
                dec_op1 = pc;
                dec_op3 = imm_j;
                dec_rd  = instr[11:7];
            end
            default: ;
        endcase
    end

    logic [4:0]  shamt;
    logic [31:0] alu_out;

    assign shamt = op2[4:0];

    always_comb begin
        alu_out = '0;
        case (funct3)
            3'b000: begin
                // Immediate forms have no SUB; instr[30] is ordinary immediate data there.
                if (opcode == OPC_OP && instr[30]) alu_out = op1 - op2;
                else                               alu_out = op1 + op2;
            end
            3'b001: alu_out = op1 << shamt;
            3'b010: alu_out = {31'b0, $signed(op1) < $signed(op2)};
            3'b011: alu_out = {31'b0, op1 < op2};
            3'b100: alu_out = op1 ^ op2;
            3'b101: begin
                if (instr[30]) alu_out = $signed(op1) >>> shamt;
                else           alu_out = op1 >> shamt;
            end
            3'b110: alu_out = op1 | op2;
            3'b111: alu_out = op1 & op2;
            default: ;
        endcase
        if (opcode == OPC_LUI || opcode == OPC_AUIPC) alu_out = op1 + op2;
    end

    logic taken;

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = (op1 == op2);
            3'b001:  taken = (op1 != op2);
            3'b100:  taken = ($signed(op1) < $signed(op2));
            3'b101:  taken = !($signed(op1) < $signed(op2));
            3'b110:  taken = (op1 < op2);
            3'b111:  taken = !(op1 < op2);
            default: taken = 1'b0;
        endcase
    end

    logic [31:0] link, target, exec_result;
    logic        redirect, exec_wb, exec_fire, is_ebreak, pc_hold;

    assign link = pc + 32'd4;

    always_comb begin
        target      = pc + op3;
        redirect    = 1'b0;
        exec_result = '0;
        exec_wb     = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                exec_result = alu_out;
                exec_wb     = 1'b1;
            end
            OPC_JAL: begin
                redirect    = 1'b1;
                exec_result = link;
                exec_wb     = 1'b1;
            end
            OPC_JALR: begin
                redirect    = 1'b1;
                target      = (op1 + op2) & 32'hFFFF_FFFE;
                exec_result = link;
                exec_wb     = 1'b1;
            end
            OPC_BRANCH: redirect = taken;
            default: ;
        endcase
    end

    // Strobes are single-cycle commands from the core FSM with no backpressure:
    // decode_en wins over execute_en, and execute is ignored entirely once halted.
    assign is_ebreak = (instr == EBREAK_INSTR);
    assign exec_fire = execute_en && !decode_en && !halted;

`ifdef MISALIGN_CHECK_EN
    logic target_bad;

    assign target_bad = redirect && (target[1:0] != 2'b00);
    assign pc_hold    = target_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misaligned <= 1'b0;
        else      misaligned <= exec_fire && !is_ebreak && target_bad;
    end
`else
    assign pc_hold    = 1'b0;
    assign misaligned = 1'b0;
`endif

    logic [31:0] result_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            op1       <= '0;
            op2       <= '0;
            op3       <= '0;
            rd        <= '0;
            result_q  <= '0;
            alu_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            alu_valid <= 1'b0;
            if (decode_en) begin
                op1 <= dec_op1;
                op2 <= dec_op2;
                op3 <= dec_op3;
                rd  <= dec_rd;
            end else if (exec_fire) begin
                result_q <= exec_result;
                if (is_ebreak) begin
                    halted <= 1'b1;
                end else begin
                    alu_valid <= exec_wb;
                    if (!redirect)    pc <= link;
                    else if (!pc_hold) pc <= target;
                end
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// Directed bench for rv32i_decode_execute: vector table plus hand sequences for
// reset, strobe overlap, halt and (with MISALIGN_CHECK_EN) misaligned targets.
module tb_rv32i_decode_execute;
    logic        clk;
    logic        rst;
    logic        decode_en;
    logic        execute_en;
    logic [31:0] instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] op1, op2, op3;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] result;
    logic        alu_valid;
    logic        halted;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    rv32i_decode_execute dut (
        .clk        (clk),
        .rst        (rst),
        .decode_en  (decode_en),
        .execute_en (execute_en),
        .instr      (instr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .op1        (op1),
        .op2        (op2),
        .op3        (op3),
        .rd         (rd),
        .pc         (pc),
        .result     (result),
        .alu_valid  (alu_valid),
        .halted     (halted),
        .misaligned (misaligned)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic [31:0] start_pc;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  exp_rd;
        logic [31:0] exp_result;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        chk_ops;
        logic [31:0] exp_op1;
        logic [31:0] exp_op2;
        logic [31:0] exp_op3;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input string n, input logic [31:0] sp, input logic [31:0] ins,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] rde,
                           input logic [31:0] res, input logic [31:0] pce, input logic v,
                           input logic co, input logic [31:0] o1, input logic [31:0] o2,
                           input logic [31:0] o3);
        vec_t t;
        t.name = n; t.start_pc = sp; t.ins = ins; t.a = a; t.b = b;
        t.exp_rd = rde; t.exp_result = res; t.exp_pc = pce; t.exp_valid = v;
        t.chk_ops = co; t.exp_op1 = o1; t.exp_op2 = o2; t.exp_op3 = o3;
        vecs.push_back(t);
    endtask

    // driver tasks: all inputs change on the falling edge, outputs sampled there too
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instr = ins; rs1_data = a; rs2_data = b; decode_en = 1'b1;
        @(negedge clk);
        decode_en = 1'b0; execute_en = 1'b1;
        @(negedge clk);
        execute_en = 1'b0;
    endtask

    // JALR x0,0(x1) with rs1_data = target
    task automatic goto_pc(input logic [31:0] target);
        run_instr(32'h0000_8067, target, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; decode_en = 1'b0; execute_en = 1'b0;
        instr = 32'h0000_0013; rs1_data = '0; rs2_data = '0;

        //         name      start     instr          rs1          rs2          rd  result       pc           v  ops op1          op2          op3
        add_vec("slt",      32'h040, 32'h0020_A1B3, 32'hFFFF_FFF0, 32'h1,     5'd3, 32'h1,        32'h044, 1, 0, 0, 0, 0);
        add_vec("sltu",     32'h040, 32'h0020_B1B3, 32'hFFFF_FFF0, 32'h1,     5'd3, 32'h0,        32'h044, 1, 0, 0, 0, 0);
        add_vec("sra",      32'h040, 32'h4020_D1B3, 32'h8000_0000, 32'h4,     5'd3, 32'hF800_0000,32'h044, 1, 0, 0, 0, 0);
        add_vec("srai",     32'h040, 32'h4040_D193, 32'h8000_0000, 32'h0,     5'd3, 32'hF800_0000,32'h044, 1, 1, 32'h8000_0000, 32'h404, 32'h0);
        add_vec("srl",      32'h040, 32'h0020_D1B3, 32'h8000_0000, 32'h4,     5'd3, 32'h0800_0000,32'h044, 1, 0, 0, 0, 0);
        add_vec("sll",      32'h040, 32'h0020_91B3, 32'h1,         32'h21,    5'd3, 32'h2,        32'h044, 1, 0, 0, 0, 0);
        add_vec("sub",      32'h040, 32'h4020_81B3, 32'h5,         32'h7,     5'd3, 32'hFFFF_FFFE,32'h044, 1, 0, 0, 0, 0);
        add_vec("add_wrap", 32'h040, 32'h0020_81B3, 32'hFFFF_FFFF, 32'h1,     5'd3, 32'h0,        32'h044, 1, 0, 0, 0, 0);
        add_vec("addi_b30", 32'h040, 32'h4000_8193, 32'h1,         32'h0,     5'd3, 32'h401,      32'h044, 1, 0, 0, 0, 0);
        add_vec("xor",      32'h040, 32'h0020_C1B3, 32'hF0F0,      32'hFF00,  5'd3, 32'h0FF0,     32'h044, 1, 0, 0, 0, 0);
        add_vec("or",       32'h040, 32'h0020_E1B3, 32'hF0F0,      32'hFF00,  5'd3, 32'hFFF0,     32'h044, 1, 0, 0, 0, 0);
        add_vec("and",      32'h040, 32'h0020_F1B3, 32'hF0F0,      32'hFF00,  5'd3, 32'hF000,     32'h044, 1, 0, 0, 0, 0);
        add_vec("lui",      32'h040, 32'h1234_52B7, 32'hAAAA,      32'h0,     5'd5, 32'h1234_5000,32'h044, 1, 1, 32'h0, 32'h1234_5000, 32'h0);
        add_vec("auipc",    32'h080, 32'h0000_1297, 32'h0,         32'h0,     5'd5, 32'h1080,     32'h084, 1, 1, 32'h080, 32'h1000, 32'h0);
        add_vec("beq_t",    32'h100, 32'hFE20_8CE3, 32'h7,         32'h7,     5'd0, 32'h0,        32'h0F8, 0, 1, 32'h7, 32'h7, 32'hFFFF_FFF8);
        add_vec("beq_nt",   32'h100, 32'hFE20_8CE3, 32'h7,         32'h8,     5'd0, 32'h0,        32'h104, 0, 0, 0, 0, 0);
        add_vec("bne_t",    32'h100, 32'hFE20_9CE3, 32'h7,         32'h8,     5'd0, 32'h0,        32'h0F8, 0, 0, 0, 0, 0);
        add_vec("blt_t",    32'h100, 32'hFE20_CCE3, 32'hFFFF_FFFF, 32'h1,     5'd0, 32'h0,        32'h0F8, 0, 0, 0, 0, 0);
        add_vec("bltu_nt",  32'h100, 32'hFE20_ECE3, 32'hFFFF_FFFF, 32'h1,     5'd0, 32'h0,        32'h104, 0, 0, 0, 0, 0);
        add_vec("bge_t",    32'h100, 32'hFE20_DCE3, 32'h1,         32'hFFFF_FFFF, 5'd0, 32'h0,    32'h0F8, 0, 0, 0, 0, 0);
        add_vec("bgeu_nt",  32'h100, 32'hFE20_FCE3, 32'h1,         32'hFFFF_FFFF, 5'd0, 32'h0,    32'h104, 0, 0, 0, 0, 0);
        add_vec("jal",      32'h200, 32'h0200_00EF, 32'h0,         32'h0,     5'd1, 32'h204,      32'h220, 1, 1, 32'h200, 32'h0, 32'h20);
        add_vec("jalr",     32'h400, 32'h0000_80E7, 32'h301,       32'h0,     5'd1, 32'h404,      32'h300, 1, 1, 32'h301, 32'h0, 32'h0);
        add_vec("sw",       32'h500, 32'h0021_A223, 32'h1000,      32'hDEAD,  5'd0, 32'h0,        32'h504, 0, 1, 32'h1000, 32'h4, 32'hDEAD);
        add_vec("lw",       32'h500, 32'hFFC0_A283, 32'h100,       32'h0,     5'd5, 32'h0,        32'h504, 0, 1, 32'h100, 32'hFFFF_FFFC, 32'h0);
        add_vec("fence",    32'h500, 32'h0000_000F, 32'h0,         32'h0,     5'd0, 32'h0,        32'h504, 0, 0, 0, 0, 0);
        add_vec("illegal",  32'h500, 32'hFFFF_FFFF, 32'h5,         32'h6,     5'd0, 32'h0,        32'h504, 0, 1, 32'h0, 32'h0, 32'h0);

        // reset state and combinational register addresses
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_op1", op1, 32'h0);
        check("rst_op2", op2, 32'h0);
        check("rst_op3", op3, 32'h0);
        check("rst_rd", {27'b0, rd}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_flags", {29'b0, alu_valid, halted, misaligned}, 32'h0);
        instr = 32'h0021_A223;
        #1;
        check("rs1_addr", {27'b0, rs1_addr}, 32'd3);
        check("rs2_addr", {27'b0, rs2_addr}, 32'd2);
        rst = 1'b1;

        // execute with no prior decode runs on reset operands
        @(negedge clk);
        instr = 32'h0050_0093; execute_en = 1'b1;
        @(negedge clk);
        execute_en = 1'b0;
        check("nodec_result", result, 32'h0);
        check("nodec_rd", {27'b0, rd}, 32'h0);
        check("nodec_pc", pc, 32'h4);
        check("nodec_valid", {31'b0, alu_valid}, 32'h1);

        do_reset();
        check("rst2_pc", pc, 32'h0);
        check("rst2_valid", {31'b0, alu_valid}, 32'h0);

        // ADDI x1,x0,5 from reset, then the valid pulse drops
        run_instr(32'h0050_0093, 32'h0, 32'h0);
        check("addi_rd", {27'b0, rd}, 32'd1);
        check("addi_result", result, 32'd5);
        check("addi_pc", pc, 32'h4);
        check("addi_valid", {31'b0, alu_valid}, 32'h1);
        @(negedge clk);
        check("addi_valid_drop", {31'b0, alu_valid}, 32'h0);

        // decode and execute together: decode wins
        @(negedge clk);
        instr = 32'h0090_0113; decode_en = 1'b1; execute_en = 1'b1;
        @(negedge clk);
        decode_en = 1'b0; execute_en = 1'b0;
        check("both_op2", op2, 32'd9);
        check("both_rd", {27'b0, rd}, 32'd2);
        check("both_pc", pc, 32'h4);
        check("both_result", result, 32'd5);
        check("both_valid", {31'b0, alu_valid}, 32'h0);
        @(negedge clk);
        execute_en = 1'b1;
        @(negedge clk);
        execute_en = 1'b0;
        check("after_both_result", result, 32'd9);
        check("after_both_pc", pc, 32'h8);

        // table-driven vectors
        foreach (vecs[i]) begin
            goto_pc(vecs[i].start_pc);
            check({vecs[i].name, "_start"}, pc, vecs[i].start_pc);
            run_instr(vecs[i].ins, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_rd"}, {27'b0, rd}, {27'b0, vecs[i].exp_rd});
            check({vecs[i].name, "_result"}, result, vecs[i].exp_result);
            check({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
            check({vecs[i].name, "_valid"}, {31'b0, alu_valid}, {31'b0, vecs[i].exp_valid});
            check({vecs[i].name, "_misaligned"}, {31'b0, misaligned}, 32'h0);
            if (vecs[i].chk_ops) begin
                check({vecs[i].name, "_op1"}, op1, vecs[i].exp_op1);
                check({vecs[i].name, "_op2"}, op2, vecs[i].exp_op2);
                check({vecs[i].name, "_op3"}, op3, vecs[i].exp_op3);
            end
        end

        // EBREAK halts; later execute strobes are ignored
        goto_pc(32'h700);
        run_instr(32'h0010_0073, 32'h0, 32'h0);
        check("ebreak_halted", {31'b0, halted}, 32'h1);
        check("ebreak_pc", pc, 32'h700);
        check("ebreak_rd", {27'b0, rd}, 32'h0);
        check("ebreak_valid", {31'b0, alu_valid}, 32'h0);
        run_instr(32'h0050_0093, 32'h0, 32'h0);
        check("halt_pc", pc, 32'h700);
        check("halt_valid", {31'b0, alu_valid}, 32'h0);
        check("halt_result", result, 32'h0);
        check("halt_sticky", {31'b0, halted}, 32'h1);
        do_reset();
        check("unhalt", {31'b0, halted}, 32'h0);

        // asynchronous reset in the middle of an instruction
        goto_pc(32'h600);
        @(negedge clk);
        instr = 32'h0050_0093; rs1_data = '0; decode_en = 1'b1;
        @(negedge clk);
        decode_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_pc", pc, 32'h0);
        check("midrst_op2", op2, 32'h0);
        check("midrst_rd", {27'b0, rd}, 32'h0);
        check("midrst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // JAL x1,+2 : misaligned target
        goto_pc(32'h800);
        run_instr(32'h0020_00EF, 32'h0, 32'h0);
        check("jal2_result", result, 32'h804);
        check("jal2_valid", {31'b0, alu_valid}, 32'h1);
`ifdef MISALIGN_CHECK_EN
        check("jal2_pc", pc, 32'h800);
        check("jal2_misaligned", {31'b0, misaligned}, 32'h1);
`else
        check("jal2_pc", pc, 32'h802);
        check("jal2_misaligned", {31'b0, misaligned}, 32'h0);
`endif
        @(negedge clk);
        check("jal2_misaligned_drop", {31'b0, misaligned}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
